weight_feed_ctrl: RTL

WEIGHT_FEED_CTRL -- requirements
Module: weight_feed_ctrl

---
 rtl/weight_feed_ctrl_pkg.sv | 30 +++
 rtl/weight_mux_reg.sv | 29 ++
 rtl/weight_feed_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/weight_feed_ctrl_pkg.sv
// weight_feed_ctrl_pkg: shared FSM encoding, bitwidth/mux codes and feed-cycle lookup
// Contents: state_t (IDLE/FETCH/FEED/DONE), BW_* input bitwidth codes,
// MUX_HOLD mux-register code, feed_last_phase() = N-1 for a bitwidth code.
package weight_feed_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] BW_2 = 2'b00;
    localparam logic [1:0] BW_4 = 2'b01;
    localparam logic [1:0] BW_8 = 2'b10;

    // Mux-register bitwidth input code that freezes its internal phase.
    localparam logic [1:0] MUX_HOLD = 2'b00;

    // Last phase index of a word: N-1 with N = 1, 2, 4 for 2b, 4b, 8b (11 aliases 8b).
    function automatic logic [1:0] feed_last_phase(input logic [1:0] bw);
        return (bw == BW_2) ? 2'd0 : (bw == BW_4) ? 2'd1 : 2'd3;
    endfunction

    // Next internal phase of the mux register for a given bitwidth code.
    function automatic logic [1:0] mux_next_phase(input logic [1:0] bw, input logic [1:0] p);
        return (bw == MUX_HOLD) ? p : (bw == BW_4) ? {1'b0, ~p[0]} : p + 2'd1;
    endfunction

endpackage

// File: rtl/weight_mux_reg.sv
// weight_mux_reg: weight mux register that slices a 32-bit buffer word by input bitwidth
// Ports: clk, reset (sync, active-high); bitwidth (00 = 2b / hold phase,
// 01 = 4b, 1x = 8b); buffer (word); out (selected sub-word replicated to 32 bits);
// phase (internal sub-word index, advances on every non-hold cycle).
module weight_mux_reg
    import weight_feed_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bitwidth,
    input  logic [31:0] buffer,
    output logic [31:0] out,
    output logic [1:0]  phase
);

    logic [1:0] p;

    always_ff @(posedge clk) begin
        if (reset)
            p <= 2'd0;
        else
            p <= mux_next_phase(bitwidth, p);
    end

    assign phase = p;
    assign out   = bitwidth[1] ? {4{buffer[{p, 3'b000} +: 8]}} :
                   bitwidth[0] ? {2{buffer[{p[0], 4'b0000} +: 16]}} : buffer;

endmodule

// File: rtl/weight_feed_ctrl.sv
// weight_feed_ctrl: streams weight-buffer words into the weight mux register without bubbles
// Ports: clk, reset (sync, active-high); start + cfg_bitwidth/cfg_base_addr/cfg_num_words
// (latched on accepted start); stall (downstream pause); buf_rd_en/buf_rd_addr/buf_rd_data
// (buffer read port, data one cycle after strobe); mux_bitwidth/mux_buffer (mux-register
// drive); feed_valid, phase (sub-word index), busy, done (one-cycle end-of-pass pulse).
module weight_feed_ctrl
    import weight_feed_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_bitwidth,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W:0]   cfg_num_words,
    input  logic              stall,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [1:0]        mux_bitwidth,
    output logic [DATA_W-1:0] mux_buffer,
    output logic              feed_valid,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nx;
    logic [1:0]        bw;
    logic [1:0]        ph;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem;
    logic              rd_pend;
    logic [DATA_W-1:0] word;
    logic              last_ph;
    logic              more;

    // addr is always the next address to read; rem counts words not yet read.
    assign last_ph = ph == feed_last_phase(bw);
    assign more    = rem != '0;

    always_comb begin
        state_nx   = state;
        buf_rd_en  = 1'b0;
        feed_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (cfg_num_words == '0) ? DONE : FETCH;
            end
            FETCH: begin
                buf_rd_en = 1'b1;
                state_nx  = FEED;
            end
            FEED: begin
                if (!stall) begin
                    feed_valid = 1'b1;
                    if (last_ph) begin
                        buf_rd_en = more;
                        state_nx  = more ? FEED : DONE;
                    end
                end
            end
            DONE: state_nx = IDLE;
        endcase
    end

    assign buf_rd_addr  = addr;
    assign mux_bitwidth = feed_valid ? bw : MUX_HOLD;
    // Forward the fresh read word in its arrival cycle so words follow back to back.
    assign mux_buffer   = rd_pend ? buf_rd_data : word;
    assign phase        = ph;
    assign busy         = (state == FETCH) || (state == FEED);
    assign done         = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bw      <= 2'b00;
            ph      <= 2'd0;
            addr    <= '0;
            rem     <= '0;
            rd_pend <= 1'b0;
            word    <= '0;
        end else begin
            state   <= state_nx;
            rd_pend <= buf_rd_en;
            if (rd_pend)
                word <= buf_rd_data;
            if (state == IDLE && start) begin
                bw   <= cfg_bitwidth;
                addr <= cfg_base_addr;
                rem  <= cfg_num_words;
                ph   <= 2'd0;
            end
            if (buf_rd_en) begin
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
            end
            if (feed_valid)
                ph <= last_ph ? 2'd0 : ph + 2'd1;
        end
    end

endmodule
